// File: rtl/fmrv32im_uart_pkg.sv
// fmrv32im_uart_pkg: register map, STATUS bit positions, response codes and FSM states for the AXI-Lite UART
package fmrv32im_uart_pkg;
   localparam logic [1:0] REG_DATA   = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_CTRL   = 2'd2;
   localparam logic [1:0] REG_BAUD   = 2'd3;
   localparam int ST_TX_FULL  = 0;
   localparam int ST_TX_EMPTY = 1;
   localparam int ST_RX_VALID = 2;
   localparam int ST_OVERRUN  = 3;
   localparam int ST_FRM_ERR  = 4;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
endpackage

// File: rtl/fmrv32im_sync_fifo.sv
// fmrv32im_sync_fifo: single-clock FIFO with full/empty flags; push and pop in one cycle keep the count
module fmrv32im_sync_fifo #(
   parameter int W          = 8,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                push_i,
   input  logic [W-1:0]        data_i,
   input  logic                pop_i,
   output logic [W-1:0]        data_o,
   output logic                full_o,
   output logic                empty_o,
   output logic [DEPTH_LOG2:0] count_o
);
   logic [W-1:0]          mem_q [2**DEPTH_LOG2];
   logic [DEPTH_LOG2-1:0] wr_q, rd_q;
   logic [DEPTH_LOG2:0]   cnt_q;
   logic                  do_push, do_pop;
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign full_o  = cnt_q[DEPTH_LOG2];
   assign empty_o = cnt_q == '0;
   assign data_o  = mem_q[rd_q];
   assign count_o = cnt_q;
   always_ff @(posedge clk_i)
      if (do_push) mem_q[wr_q] <= data_i;
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + 1'b1;
         if (do_pop) rd_q <= rd_q + 1'b1;
         cnt_q <= cnt_q + (DEPTH_LOG2+1)'(do_push) - (DEPTH_LOG2+1)'(do_pop);
      end
endmodule

// File: rtl/fmrv32im_axils_uart.sv
// fmrv32im_axils_uart: AXI4-Lite slave UART (8N1, LSB first) with TX FIFO, RX holding register
// and a registered level interrupt.
module fmrv32im_axils_uart
   import fmrv32im_uart_pkg::*;
#(
   parameter int          TX_DEPTH_LOG2 = 4,
   parameter logic [15:0] BAUD_DIV_RST  = 16'd868
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [31:0] S_AXI_AWADDR,
   input  logic [3:0]  S_AXI_AWCACHE,
   input  logic [2:0]  S_AXI_AWPROT,
   input  logic        S_AXI_AWVALID,
   output logic        S_AXI_AWREADY,
   input  logic [31:0] S_AXI_WDATA,
   input  logic [3:0]  S_AXI_WSTRB,
   input  logic        S_AXI_WVALID,
   output logic        S_AXI_WREADY,
   output logic        S_AXI_BVALID,
   input  logic        S_AXI_BREADY,
   output logic [1:0]  S_AXI_BRESP,
   input  logic [31:0] S_AXI_ARADDR,
   input  logic [3:0]  S_AXI_ARCACHE,
   input  logic [2:0]  S_AXI_ARPROT,
   input  logic        S_AXI_ARVALID,
   output logic        S_AXI_ARREADY,
   output logic [31:0] S_AXI_RDATA,
   output logic [1:0]  S_AXI_RRESP,
   output logic        S_AXI_RVALID,
   input  logic        S_AXI_RREADY,
   input  logic        UART_RXD,
   output logic        UART_TXD,
   output logic        INTERRUPT
);
   logic        awready_q, arready_q, bvalid_q, rvalid_q, txd_q, irq_q;
   logic [1:0]  bresp_q, ctrl_q;
   logic [31:0] rdata_q, rd_mux;
   logic [15:0] baud_q, tx_cnt_q, tx_div_q, rx_cnt_q, rx_div_q;
   logic [7:0]  tx_sh_q, rx_sh_q, rx_byte_q, tx_data;
   logic [2:0]  tx_bit_q, rx_bit_q;
   logic [1:0]  rx_sync_q;
   logic        rx_prev_q, rx_valid_q, overrun_q, frm_err_q;
   logic [4:0]  status;
   logic [1:0]  wa, ra;
   logic        wr_en, rd_en, wr_any, push, rx_pop, st_clr, tx_full, tx_empty, tx_bnd, tx_pop, rx_bnd, rxs;
   logic [TX_DEPTH_LOG2:0] tx_count;
   tx_state_t   tx_q;
   rx_state_t   rx_q;
   assign S_AXI_AWREADY = awready_q;
   assign S_AXI_WREADY  = awready_q;
   assign S_AXI_ARREADY = arready_q;
   assign S_AXI_BVALID  = bvalid_q;
   assign S_AXI_BRESP   = bresp_q;
   assign S_AXI_RVALID  = rvalid_q;
   assign S_AXI_RDATA   = rdata_q;
   assign S_AXI_RRESP   = RESP_OKAY;
   assign UART_TXD      = txd_q;
   assign INTERRUPT     = irq_q;
   assign wa     = S_AXI_AWADDR[3:2];
   assign ra     = S_AXI_ARADDR[3:2];
   assign wr_en  = awready_q && S_AXI_AWVALID && S_AXI_WVALID;
   assign rd_en  = arready_q && S_AXI_ARVALID;
   assign wr_any = wr_en && |S_AXI_WSTRB;
   assign push   = wr_any && wa == REG_DATA && !tx_full;
   assign rx_pop = rd_en && ra == REG_DATA;
   assign st_clr = rd_en && ra == REG_STATUS;
   assign rxs    = rx_sync_q[1];
   assign tx_bnd = tx_cnt_q == tx_div_q - 16'd1;
   assign tx_pop = !tx_empty && (tx_q == TX_IDLE || (tx_q == TX_STOP && tx_bnd));
   // the start bit is sampled mid-bit so that every later sample lands in the middle of its bit
   assign rx_bnd = rx_cnt_q == (rx_q == RX_START ? {1'b0, rx_div_q[15:1]} : rx_div_q - 16'd1);
   always_comb begin
      status              = '0;
      status[ST_TX_FULL]  = tx_full;
      status[ST_TX_EMPTY] = tx_empty;
      status[ST_RX_VALID] = rx_valid_q;
      status[ST_OVERRUN]  = overrun_q;
      status[ST_FRM_ERR]  = frm_err_q;
   end
   assign rd_mux = ra == REG_DATA   ? {24'd0, rx_valid_q ? rx_byte_q : 8'd0} :
                   ra == REG_STATUS ? {27'd0, status} :
                   ra == REG_CTRL   ? {30'd0, ctrl_q} : {16'd0, baud_q};
   fmrv32im_sync_fifo #(.W(8), .DEPTH_LOG2(TX_DEPTH_LOG2)) u_tx_fifo (
      .clk_i(CLK), .rst_i(RST), .push_i(push), .data_i(S_AXI_WDATA[7:0]), .pop_i(tx_pop),
      .data_o(tx_data), .full_o(tx_full), .empty_o(tx_empty), .count_o(tx_count)
   );
   always_ff @(posedge CLK or posedge RST)
      if (RST) begin
         awready_q <= 1'b0;
         arready_q <= 1'b0;
         bvalid_q  <= 1'b0;
         rvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
         rdata_q   <= '0;
         ctrl_q    <= '0;
         baud_q    <= BAUD_DIV_RST;
         irq_q     <= 1'b0;
      end else begin
         awready_q <= S_AXI_AWVALID && S_AXI_WVALID && !bvalid_q && !awready_q;
         arready_q <= S_AXI_ARVALID && !rvalid_q && !arready_q;
         if (wr_en) begin
            bvalid_q <= 1'b1;
            bresp_q  <= (wa == REG_DATA && tx_full) ? RESP_SLVERR : RESP_OKAY;
         end else if (S_AXI_BREADY) bvalid_q <= 1'b0;
         if (rd_en) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_mux;
         end else if (S_AXI_RREADY) rvalid_q <= 1'b0;
         if (wr_any && wa == REG_CTRL) ctrl_q <= S_AXI_WDATA[1:0];
         if (wr_any && wa == REG_BAUD) baud_q <= S_AXI_WDATA[15:1] == '0 ? 16'd2 : S_AXI_WDATA[15:0];
         irq_q <= (ctrl_q[0] && rx_valid_q) || (ctrl_q[1] && tx_empty && tx_q == TX_IDLE);
      end
   always_ff @(posedge CLK or posedge RST)
      if (RST) begin
         tx_q     <= TX_IDLE;
         txd_q    <= 1'b1;
         tx_cnt_q <= '0;
         tx_div_q <= BAUD_DIV_RST;
         tx_bit_q <= '0;
         tx_sh_q  <= '0;
      end else if (tx_pop) begin
         tx_q     <= TX_START;
         txd_q    <= 1'b0;
         tx_sh_q  <= tx_data;
         tx_cnt_q <= '0;
         tx_div_q <= baud_q;
      end else if (tx_q != TX_IDLE) begin
         if (!tx_bnd) tx_cnt_q <= tx_cnt_q + 16'd1;
         else begin
            tx_cnt_q <= '0;
            tx_div_q <= baud_q;
            if (tx_q == TX_STOP) begin
               tx_q  <= TX_IDLE;
               txd_q <= 1'b1;
            end else if (tx_q == TX_DATA && tx_bit_q == 3'd7) begin
               tx_q  <= TX_STOP;
               txd_q <= 1'b1;
            end else begin
               tx_q     <= TX_DATA;
               tx_bit_q <= tx_q == TX_START ? 3'd0 : tx_bit_q + 3'd1;
               txd_q    <= tx_sh_q[0];
               tx_sh_q  <= tx_sh_q >> 1;
            end
         end
      end
   // host-side pop/clear come first so a byte or error landing in the same cycle wins
   always_ff @(posedge CLK or posedge RST)
      if (RST) begin
         rx_sync_q  <= 2'b11;
         rx_prev_q  <= 1'b1;
         rx_q       <= RX_IDLE;
         rx_cnt_q   <= '0;
         rx_div_q   <= BAUD_DIV_RST;
         rx_bit_q   <= '0;
         rx_sh_q    <= '0;
         rx_byte_q  <= '0;
         rx_valid_q <= 1'b0;
         overrun_q  <= 1'b0;
         frm_err_q  <= 1'b0;
      end else begin
         rx_sync_q <= {rx_sync_q[0], UART_RXD};
         rx_prev_q <= rxs;
         if (rx_pop) rx_valid_q <= 1'b0;
         if (st_clr) begin
            overrun_q <= 1'b0;
            frm_err_q <= 1'b0;
         end
         if (rx_q == RX_IDLE) begin
            if (rx_prev_q && !rxs) begin
               rx_q     <= RX_START;
               rx_cnt_q <= '0;
               rx_div_q <= baud_q;
            end
         end else if (!rx_bnd) rx_cnt_q <= rx_cnt_q + 16'd1;
         else begin
            rx_cnt_q <= '0;
            if (rx_q == RX_START) begin
               rx_q     <= rxs ? RX_IDLE : RX_DATA;
               rx_bit_q <= '0;
            end else if (rx_q == RX_DATA) begin
               rx_sh_q  <= {rxs, rx_sh_q[7:1]};
               rx_bit_q <= rx_bit_q + 3'd1;
               if (rx_bit_q == 3'd7) rx_q <= RX_STOP;
            end else begin
               rx_q <= RX_IDLE;
               if (!rxs) frm_err_q <= 1'b1;
               else if (rx_valid_q && !rx_pop) overrun_q <= 1'b1;
               else begin
                  rx_byte_q  <= rx_sh_q;
                  rx_valid_q <= 1'b1;
               end
            end
         end
      end
   logic unused;
   assign unused = ^{S_AXI_AWADDR[31:4], S_AXI_AWADDR[1:0], S_AXI_ARADDR[31:4], S_AXI_ARADDR[1:0],
                     S_AXI_AWCACHE, S_AXI_ARCACHE, S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_WDATA[31:16], tx_count};
endmodule
